// File: rtl/ram_loader.sv
// ram_loader: start-triggered load sequencer. Routes the first DATA_WORDS
// stream words to the data RAM and the next WEIGHT_WORDS to the weight RAM
// through ram_mux, then raises a sticky load_done.
module ram_loader #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DATA_WORDS   = 64,
  parameter int unsigned WEIGHT_WORDS = 54,
  parameter logic        MODE_DATA    = 1'b0,
  parameter logic        MODE_WEIGHT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mode,
  output logic                  ram_en,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  load_done
);

  localparam int unsigned MAX_WORDS = (DATA_WORDS > WEIGHT_WORDS) ? DATA_WORDS : WEIGHT_WORDS;
  localparam int unsigned CW        = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] DATA_LAST   = CW'(DATA_WORDS - 1);
  localparam logic [CW-1:0] WEIGHT_LAST = CW'(WEIGHT_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_DATA,
    LOAD_WEIGHT,
    DONE
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  mode_q;
  logic                  ram_en_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  done_q;
  logic                  xfer;

  // Ready depends on state only; a transfer needs both sides.
  always_comb begin
    in_ready = (state_q == LOAD_DATA) || (state_q == LOAD_WEIGHT);
    xfer     = in_ready && in_valid;
  end

  // Sequencer FSM with registered RAM-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= MODE_DATA;
      ram_en_q <= 1'b0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      ram_en_q <= 1'b0;
      if (xfer) begin
        ram_en_q <= 1'b1;
        wdata_q  <= in_data;
      end
      case (state_q)
        IDLE: begin
          if (start) state_q <= LOAD_DATA;
        end
        LOAD_DATA: begin
          if (xfer) begin
            mode_q <= MODE_DATA;
            if (cnt_q == DATA_LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_WEIGHT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LOAD_WEIGHT: begin
          if (xfer) begin
            mode_q <= MODE_WEIGHT;
            if (cnt_q == WEIGHT_LAST) begin
              cnt_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= DONE;
        end
      endcase
    end
  end

  assign mode      = mode_q;
  assign ram_en    = ram_en_q;
  assign ram_wdata = wdata_q;
  assign load_done = done_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: word-count based reference model compared every
// cycle, plus literal spot checks on reset, boundaries and word order.
module tb_ram_loader;

  localparam int DW    = 8;
  localparam int NDATA = 64;
  localparam int NWGT  = 54;
  localparam int TOTAL = NDATA + NWGT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mode;
  logic          ram_en;
  logic [DW-1:0] ram_wdata;
  logic          load_done;

  int checks   = 0;
  int failures = 0;

  ram_loader #(
    .DATA_WIDTH  (DW),
    .DATA_WORDS  (NDATA),
    .WEIGHT_WORDS(NWGT),
    .MODE_DATA   (1'b0),
    .MODE_WEIGHT (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mode     (mode),
    .ram_en   (ram_en),
    .ram_wdata(ram_wdata),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a load is "started" once, then the n-th accepted word
  // goes to the data RAM if n < NDATA, else the weight RAM; done when n==TOTAL.
  bit            m_started = 1'b0;
  int            m_n       = 0;
  logic          m_en      = 1'b0;
  logic          m_mode    = 1'b0;
  logic [DW-1:0] m_wdata   = '0;
  logic          m_done    = 1'b0;
  logic [DW-1:0] acc_q[$];
  logic [DW:0]   cap_q[$];

  function automatic logic m_ready();
    return m_started && (m_n < TOTAL);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 1'b0; m_n = 0; m_en = 1'b0;
      m_mode = 1'b0; m_wdata = '0; m_done = 1'b0;
    end else begin
      m_en = 1'b0;
      if (!m_started) begin
        if (start) m_started = 1'b1;
      end else if (m_n < TOTAL && in_valid) begin
        m_en    = 1'b1;
        m_wdata = in_data;
        m_mode  = (m_n >= NDATA);
        acc_q.push_back(in_data);
        m_n++;
        if (m_n == TOTAL) m_done = 1'b1;
      end
    end
  end

  // Per-cycle comparison, plus capture of every write the DUT performs.
  always @(negedge clk) begin
    chk("ram_en", ram_en, m_en);
    chk("mode", mode, m_mode);
    chk("ram_wdata", ram_wdata, m_wdata);
    chk("load_done", load_done, m_done);
    chk("in_ready", in_ready, m_ready());
    if (ram_en === 1'b1) cap_q.push_back({mode, ram_wdata});
  end

  task automatic step(input bit v, input logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    #1;
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_load_done"}, load_done, 0);
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_cap_count"}, cap_q.size(), TOTAL);
    chk({tag, "_acc_count"}, acc_q.size(), TOTAL);
    if (cap_q.size() == TOTAL && acc_q.size() == TOTAL) begin
      for (int i = 0; i < TOTAL; i++) begin
        chk({tag, "_data"}, cap_q[i][DW-1:0], acc_q[i]);
        chk({tag, "_wmode"}, cap_q[i][DW], (i >= NDATA) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset values, then valid while idle is ignored.
    #2;
    reset_outputs_zero("rst");
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, DW'(8'hC0 + i));
    chk("idle_no_write", cap_q.size(), 0);

    // Back-to-back load of 0..117.
    start = 1'b1; step(1'b0, '0); start = 1'b0;
    for (int i = 0; i < TOTAL; i++) step(1'b1, DW'(i));
    chk("b2b_last_en", ram_en, 1);
    chk("b2b_last_data", ram_wdata, 117);
    chk("b2b_last_mode", mode, 1);
    chk("b2b_done", load_done, 1);
    chk("b2b_count", cap_q.size(), TOTAL);
    if (cap_q.size() == TOTAL) begin
      chk("b2b_w63", cap_q[63], {1'b0, 8'd63});
      chk("b2b_w64", cap_q[64], {1'b1, 8'd64});
      for (int i = 0; i < TOTAL; i++) chk("b2b_seq", cap_q[i][DW-1:0], i);
    end

    // Overrun after done, with a start pulse.
    start = 1'b1; step(1'b1, 8'h5A); start = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom));
    chk("ovr_ready", in_ready, 0);
    chk("ovr_en", ram_en, 0);
    chk("ovr_done", load_done, 1);
    chk("ovr_count", cap_q.size(), TOTAL);

    // Reset, then start colliding with a valid word.
    rst_n = 1'b0; #1;
    reset_outputs_zero("rst2");
    acc_q.delete(); cap_q.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0;
    chk("coll_no_write", ram_en, 0);
    chk("coll_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("coll_first_en", ram_en, 1);
    chk("coll_first_data", ram_wdata, 8'hAA);
    @(negedge clk); #1;

    // Gapped stream interrupted by reset after word 30.
    guard = 0;
    while (m_n < 30 && guard < 2000) begin
      step(1'($urandom_range(0, 1)), DW'($urandom));
      guard++;
    end
    chk("mid_reached30", (m_n == 30) ? 1 : 0, 1);
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    reset_outputs_zero("midrst");
    acc_q.delete(); cap_q.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Full gapped load after reset; gaps straddle the data/weight boundary.
    start = 1'b1; step(1'b0, '0); start = 1'b0;
    guard = 0;
    while (m_n < TOTAL && guard < 4000) begin
      step((m_n >= 60 && m_n <= 68) ? 1'($urandom_range(0, 1) & $urandom_range(0, 1))
                                    : 1'($urandom_range(0, 3) != 0), DW'($urandom));
      guard++;
    end
    chk("gap_timeout", (m_n == TOTAL) ? 1 : 0, 1);
    step(1'b0, '0);
    step(1'b1, 8'h11);
    chk("gap_done", load_done, 1);
    chk("gap_ready", in_ready, 0);
    check_order("gap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
